// File: rtl/cpu_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package cpu_fetch_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] INSTR_NOP   = 32'h0000_0013;

endpackage

// File: rtl/cpu_fetch_ctrl.sv
// Fetch sequencer: requests instruction words at pc_cur, hands them to decode and steers PC loads.
// Optional misaligned-redirect trap enabled by defining CPU_FETCH_MISALIGN_CHK_EN.
module cpu_fetch_ctrl
  import cpu_fetch_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = ADDR_WIDTH'(32'h0000_0004)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] pc_cur,
  output logic                  pc_ld,
  output logic [ADDR_WIDTH-1:0] pc_next,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [31:0]           imem_rdata,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fault
);

  fetch_state_t          state_q, state_d;
  logic                  flush_q, flush_d;
  logic                  instr_valid_q, instr_valid_d;
  logic [31:0]           instr_q, instr_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;

  logic [ADDR_WIDTH-1:0] redir_target;
  logic                  redir_fault;

`ifdef CPU_FETCH_MISALIGN_CHK_EN
  always_comb begin
    redir_fault  = (redirect_pc[1:0] != 2'b00);
    redir_target = redir_fault ? TRAP_VECTOR : redirect_pc;
  end
`else
  // Low bits are simply dropped so a misaligned target lands on its word.
  always_comb begin
    redir_fault  = 1'b0;
    redir_target = redirect_pc & ~ADDR_WIDTH'(3);
  end
`endif

  assign imem_addr   = pc_cur;
  assign instr_valid = instr_valid_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  always_comb begin
    state_d       = state_q;
    flush_d       = flush_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    imem_req      = 1'b0;
    pc_ld         = 1'b0;
    pc_next       = pc_cur + ADDR_WIDTH'(INSTR_BYTES);
    fault         = 1'b0;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        imem_req = 1'b1;
        // A grant coinciding with a redirect fetched the stale PC; drop its response.
        if (imem_gnt) begin
          state_d = WAIT;
          flush_d = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
          flush_d = 1'b0;
          if (!redirect_valid && !flush_q) begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_cur;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end else if (redirect_valid) begin
          flush_d = 1'b1;
        end
      end
      HOLD: begin
        if (redirect_valid || instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = REQ;
        end
        if (instr_ready) pc_ld = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      pc_ld   = 1'b1;
      pc_next = redir_target;
      fault   = redir_fault;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      flush_q       <= 1'b0;
      instr_valid_q <= 1'b0;
      instr_q       <= INSTR_NOP;
      instr_pc_q    <= '0;
    end else begin
      state_q       <= state_d;
      flush_q       <= flush_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Directed bench for cpu_fetch_ctrl; models the external PC register and drives the memory port.
module tb_cpu_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_cur = '0;
  logic        pc_ld;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        fault;

  int total = 0;
  int bad   = 0;

  cpu_fetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_cur         (pc_cur),
    .pc_ld          (pc_ld),
    .pc_next        (pc_next),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fault          (fault)
  );

  always #5 clk = ~clk;

  // Stand-in for the program counter register outside the block.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_cur <= '0;
    else if (pc_ld) pc_cur <= pc_next;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // From REQ: grant, respond one cycle later, leaves the DUT in HOLD.
  task automatic fetch_to_hold(input logic [31:0] data);
    imem_gnt = 1'b1;
    tick();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    tick();
    imem_rvalid = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    #1;
    total++;
    if ({pc_ld, imem_req, instr_valid, fault} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctl got=%b want=0000", {pc_ld, imem_req, instr_valid, fault});
    end
    total++;
    if (instr !== 32'h0000_0013 || instr_pc !== 32'h0) begin
      bad++;
      $display("FAIL reset_instr got=%h/%h want=00000013/00000000", instr, instr_pc);
    end
    rst_n = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL idle_req got=%b want=0", imem_req);
    end
    tick();
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL first_req got=%b/%h want=1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_pc;
      exp_pc = 32'(4 * k);
      #1;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== exp_pc || pc_ld !== 1'b0) begin
        bad++;
        $display("FAIL seq_req%0d got=%b/%h/%b want=1/%h/0", k, imem_req, imem_addr, pc_ld, exp_pc);
      end
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      #1;
      total++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL seq_wait%0d got=%b/%b want=0/0", k, imem_req, instr_valid);
      end
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hA000_0000 + 32'(k);
      tick();
      imem_rvalid = 1'b0;
      #1;
      total++;
      if (instr_valid !== 1'b1 || instr !== 32'hA000_0000 + 32'(k) || instr_pc !== exp_pc) begin
        bad++;
        $display("FAIL seq_instr%0d got=%b/%h/%h want=1/%h/%h", k, instr_valid, instr, instr_pc,
                 32'hA000_0000 + 32'(k), exp_pc);
      end
      instr_ready = 1'b1;
      #1;
      total++;
      if (pc_ld !== 1'b1 || pc_next !== exp_pc + 32'd4) begin
        bad++;
        $display("FAIL seq_pcld%0d got=%b/%h want=1/%h", k, pc_ld, pc_next, exp_pc + 32'd4);
      end
      tick();
      instr_ready = 1'b0;
      #1;
      total++;
      if (instr_valid !== 1'b0) begin
        bad++;
        $display("FAIL seq_drop%0d got=%b want=0", k, instr_valid);
      end
    end
  endtask

  task automatic test_gnt_stall();
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'hC || pc_ld !== 1'b0) begin
        bad++;
        $display("FAIL stall%0d got=%b/%h/%b want=1/0000000c/0", i, imem_req, imem_addr, pc_ld);
      end
      tick();
    end
    fetch_to_hold(32'h1111_1111);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    imem_gnt = 1'b1;
    tick();
    imem_gnt       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    #1;
    total++;
    if (pc_ld !== 1'b1 || pc_next !== 32'h100 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rw_load got=%b/%h/%b want=1/00000100/0", pc_ld, pc_next, imem_req);
    end
    tick();
    redirect_valid = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'hDEAD_BEEF;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rw_noreq got=%b want=0", imem_req);
    end
    tick();
    imem_rvalid = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL rw_discard got=%b/%b/%h want=0/1/00000100", instr_valid, imem_req, imem_addr);
    end
    fetch_to_hold(32'h0000_1234);
    #1;
    total++;
    if (instr_valid !== 1'b1 || instr !== 32'h0000_1234 || instr_pc !== 32'h100) begin
      bad++;
      $display("FAIL rw_refetch got=%b/%h/%h want=1/00001234/00000100", instr_valid, instr, instr_pc);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_hold();
    fetch_to_hold(32'h2222_2222);
    instr_ready    = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    #1;
    total++;
    if (pc_ld !== 1'b1 || pc_next !== 32'h200) begin
      bad++;
      $display("FAIL rh_load got=%b/%h want=1/00000200", pc_ld, pc_next);
    end
    tick();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      bad++;
      $display("FAIL rh_after got=%b/%b/%h want=0/1/00000200", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_rvalid();
    imem_gnt = 1'b1;
    tick();
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b1;
    imem_rdata     = 32'h3333_3333;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    imem_rvalid    = 1'b0;
    redirect_valid = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      bad++;
      $display("FAIL rr_discard got=%b/%b/%h want=0/1/00000300", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_req got=%b/%h want=1/fffffffc", imem_req, imem_addr);
    end
    fetch_to_hold(32'h4444_4444);
    instr_ready = 1'b1;
    #1;
    total++;
    if (instr_pc !== 32'hFFFF_FFFC || pc_ld !== 1'b1 || pc_next !== 32'h0) begin
      bad++;
      $display("FAIL wrap_next got=%h/%b/%h want=fffffffc/1/00000000", instr_pc, pc_ld, pc_next);
    end
    tick();
    instr_ready = 1'b0;
    #1;
    total++;
    if (imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL wrap_addr got=%h want=00000000", imem_addr);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] exp_next;
    logic        exp_fault;
`ifdef CPU_FETCH_MISALIGN_CHK_EN
    exp_next  = 32'h0000_0004;
    exp_fault = 1'b1;
`else
    exp_next  = 32'h0000_0100;
    exp_fault = 1'b0;
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    #1;
    total++;
    if (pc_ld !== 1'b1 || pc_next !== exp_next || fault !== exp_fault) begin
      bad++;
      $display("FAIL misalign got=%b/%h/%b want=1/%h/%b", pc_ld, pc_next, fault, exp_next, exp_fault);
    end
    tick();
    redirect_valid = 1'b0;
    #1;
    total++;
    if (fault !== 1'b0 || imem_addr !== exp_next) begin
      bad++;
      $display("FAIL misalign_after got=%b/%h want=0/%h", fault, imem_addr, exp_next);
    end
  endtask

  task automatic test_reset_mid();
    fetch_to_hold(32'h5555_5555);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    imem_gnt    = 1'b1;
    tick();
    imem_gnt = 1'b0;
    rst_n    = 1'b0;
    #1;
    total++;
    if ({pc_ld, imem_req, instr_valid, fault} !== 4'b0000 || instr !== 32'h0000_0013 ||
        instr_pc !== 32'h0) begin
      bad++;
      $display("FAIL rst_mid got=%b/%h/%h want=0000/00000013/00000000",
               {pc_ld, imem_req, instr_valid, fault}, instr, instr_pc);
    end
    tick();
    rst_n       = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h6666_6666;
    tick();
    #1;
    total++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL rst_late got=%b/%b/%h want=0/1/00000000", instr_valid, imem_req, imem_addr);
    end
    tick();
    imem_rvalid = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin
      bad++;
      $display("FAIL rst_ignore got=%b/%h want=0/00000013", instr_valid, instr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_gnt_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_rvalid();
    test_wrap();
    test_misalign();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
